// File: rtl/shared_match_pe_arbiter.sv
// Round-robin arbiter sharing one match PE among NUM_REQ job-PE requesters.
// Requests are registered toward the match PE with the requester index packed
// into the upper tag bits; responses are steered back by those bits, and
// per-requester credit counters cap outstanding matches.
module shared_match_pe_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int LOCAL_TAG_W = 3,
  parameter int LEN_W       = 6,
  parameter int MAX_OUT     = 4,
  localparam int ID_W       = $clog2(NUM_REQ),
  localparam int CNT_W      = $clog2(MAX_OUT + 1),
  localparam int TAG_W      = ID_W + LOCAL_TAG_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_head_addr,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_history_addr,
  input  logic [NUM_REQ*LOCAL_TAG_W-1:0] req_local_tag,
  output logic                           match_req_valid,
  input  logic                           match_req_ready,
  output logic [ADDR_W-1:0]              match_req_head_addr,
  output logic [ADDR_W-1:0]              match_req_history_addr,
  output logic [TAG_W-1:0]               match_req_tag,
  input  logic                           match_resp_valid,
  output logic                           match_resp_ready,
  input  logic [TAG_W-1:0]               match_resp_tag,
  input  logic [LEN_W-1:0]               match_resp_match_len,
  output logic [NUM_REQ-1:0]             resp_valid,
  input  logic [NUM_REQ-1:0]             resp_ready,
  output logic [LOCAL_TAG_W-1:0]         resp_local_tag,
  output logic [LEN_W-1:0]               resp_match_len,
  output logic [NUM_REQ*CNT_W-1:0]       outstanding,
  output logic                           err_unexpected_resp
);

  logic [CNT_W-1:0]       cnt [NUM_REQ];
  logic [NUM_REQ-1:0]     elig;
  logic                   any_elig;
  logic [ID_W-1:0]        rr;
  logic [ID_W-1:0]        winner;
  logic [ID_W-1:0]        idx;
  logic                   load;
  logic                   accept;
  logic [ADDR_W-1:0]      sel_head;
  logic [ADDR_W-1:0]      sel_hist;
  logic [LOCAL_TAG_W-1:0] sel_ltag;
  logic [ID_W-1:0]        resp_id;
  logic                   id_ok;
  logic                   resp_fire;
  logic [CNT_W-1:0]       resp_cnt;
  logic [NUM_REQ-1:0]     inc_vec;
  logic [NUM_REQ-1:0]     dec_vec;

  // A requester may compete only while it has a free credit.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && (cnt[i] < CNT_W'(MAX_OUT));
    end
  end

  // Round-robin search; scanning offsets high-to-low leaves the nearest eligible index at/after rr.
  always_comb begin
    any_elig = 1'b0;
    winner   = '0;
    idx      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr) + k) % NUM_REQ);
      if (elig[idx]) begin
        any_elig = 1'b1;
        winner   = idx;
      end
    end
  end

  // Grant only when the output register can take a new entry; never while in reset.
  always_comb begin
    load   = !match_req_valid || match_req_ready;
    accept = load && any_elig && !rst;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (winner == ID_W'(i));
      inc_vec[i]   = accept && (winner == ID_W'(i));
    end
  end

  // Select the winner's payload from the flattened request buses.
  always_comb begin
    sel_head = '0;
    sel_hist = '0;
    sel_ltag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_head = req_head_addr[i*ADDR_W +: ADDR_W];
        sel_hist = req_history_addr[i*ADDR_W +: ADDR_W];
        sel_ltag = req_local_tag[i*LOCAL_TAG_W +: LOCAL_TAG_W];
      end
    end
  end

  // Response demux by tag id; an id with no requester is acknowledged and dropped.
  always_comb begin
    resp_id          = match_resp_tag[TAG_W-1:LOCAL_TAG_W];
    id_ok            = ({1'b0, resp_id} < (ID_W + 1)'(NUM_REQ));
    resp_local_tag   = match_resp_tag[LOCAL_TAG_W-1:0];
    resp_match_len   = match_resp_match_len;
    match_resp_ready = 1'b1;
    resp_cnt         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = match_resp_valid && id_ok && (resp_id == ID_W'(i));
      if (resp_id == ID_W'(i)) begin
        match_resp_ready = resp_ready[i];
        resp_cnt         = cnt[i];
      end
    end
    resp_fire = match_resp_valid && match_resp_ready && !rst;
    for (int i = 0; i < NUM_REQ; i++) begin
      dec_vec[i] = resp_fire && id_ok && (resp_id == ID_W'(i)) && (cnt[i] != '0);
    end
  end

  // Expose the registered credit counters as a flat bus.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      outstanding[i*CNT_W +: CNT_W] = cnt[i];
    end
  end

  // Output request register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_req_valid        <= 1'b0;
      match_req_head_addr    <= '0;
      match_req_history_addr <= '0;
      match_req_tag          <= '0;
      rr                     <= '0;
    end else if (load) begin
      match_req_valid <= any_elig;
      if (any_elig) begin
        match_req_head_addr    <= sel_head;
        match_req_history_addr <= sel_hist;
        match_req_tag          <= {winner, sel_ltag};
        rr                     <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
      end
    end
  end

  // Credit counters (simultaneous inc/dec cancel) and sticky unexpected-response flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt[i] <= '0;
      end
      err_unexpected_resp <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case ({inc_vec[i], dec_vec[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
      if (resp_fire && (!id_ok || (resp_cnt == '0))) begin
        err_unexpected_resp <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shared_match_pe_arbiter.sv
// Directed bench for shared_match_pe_arbiter: reset, round-robin order,
// backpressure, credit limit, response demux, simultaneous inc/dec, error flag.
module tb_shared_match_pe_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int ADDR_W      = 32;
  localparam int LOCAL_TAG_W = 3;
  localparam int LEN_W       = 6;
  localparam int MAX_OUT     = 4;
  localparam int CNT_W       = 3;
  localparam int TAG_W       = 5;

  logic                           clk;
  logic                           rst;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*ADDR_W-1:0]      req_head_addr;
  logic [NUM_REQ*ADDR_W-1:0]      req_history_addr;
  logic [NUM_REQ*LOCAL_TAG_W-1:0] req_local_tag;
  logic                           match_req_valid;
  logic                           match_req_ready;
  logic [ADDR_W-1:0]              match_req_head_addr;
  logic [ADDR_W-1:0]              match_req_history_addr;
  logic [TAG_W-1:0]               match_req_tag;
  logic                           match_resp_valid;
  logic                           match_resp_ready;
  logic [TAG_W-1:0]               match_resp_tag;
  logic [LEN_W-1:0]               match_resp_match_len;
  logic [NUM_REQ-1:0]             resp_valid;
  logic [NUM_REQ-1:0]             resp_ready;
  logic [LOCAL_TAG_W-1:0]         resp_local_tag;
  logic [LEN_W-1:0]               resp_match_len;
  logic [NUM_REQ*CNT_W-1:0]       outstanding;
  logic                           err_unexpected_resp;

  int n_cmp = 0;
  int n_bad = 0;

  shared_match_pe_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LOCAL_TAG_W(LOCAL_TAG_W),
    .LEN_W(LEN_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_head_addr(req_head_addr), .req_history_addr(req_history_addr),
    .req_local_tag(req_local_tag),
    .match_req_valid(match_req_valid), .match_req_ready(match_req_ready),
    .match_req_head_addr(match_req_head_addr),
    .match_req_history_addr(match_req_history_addr),
    .match_req_tag(match_req_tag),
    .match_resp_valid(match_resp_valid), .match_resp_ready(match_resp_ready),
    .match_resp_tag(match_resp_tag), .match_resp_match_len(match_resp_match_len),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_local_tag(resp_local_tag), .resp_match_len(resp_match_len),
    .outstanding(outstanding), .err_unexpected_resp(err_unexpected_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] out_of(input int i);
    return outstanding[i*CNT_W +: CNT_W];
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0;
    match_req_ready = 1'b0;
    match_resp_valid = 1'b0;
    match_resp_tag = '0;
    match_resp_match_len = '0;
    resp_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'hF;
    match_req_ready = 1'b1;
    match_resp_valid = 1'b0;
    match_resp_tag = '0;
    match_resp_match_len = '0;
    resp_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_req_ready got %b want 0000", req_ready); end
    n_cmp++; if (match_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mreq_valid got %b want 0", match_req_valid); end
    n_cmp++; if (match_req_head_addr !== 32'h0) begin n_bad++; $display("FAIL rst_head got %h want 0", match_req_head_addr); end
    n_cmp++; if (match_req_tag !== 5'd0) begin n_bad++; $display("FAIL rst_tag got %h want 0", match_req_tag); end
    n_cmp++; if (outstanding !== 12'd0) begin n_bad++; $display("FAIL rst_outstanding got %h want 0", outstanding); end
    n_cmp++; if (err_unexpected_resp !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b want 0", err_unexpected_resp); end
    match_resp_valid = 1'b1;
    match_resp_tag = {2'd1, 3'd6};
    resp_ready = 4'b0010;
    #1;
    n_cmp++; if (resp_valid !== 4'b0010) begin n_bad++; $display("FAIL rst_resp_valid got %b want 0010", resp_valid); end
    n_cmp++; if (resp_local_tag !== 3'd6) begin n_bad++; $display("FAIL rst_resp_ltag got %0d want 6", resp_local_tag); end
    @(negedge clk);
    #1;
    n_cmp++; if (outstanding !== 12'd0) begin n_bad++; $display("FAIL rst_no_dec got %h want 0", outstanding); end
    n_cmp++; if (err_unexpected_resp !== 1'b0) begin n_bad++; $display("FAIL rst_err_hold got %b want 0", err_unexpected_resp); end
  endtask

  task automatic test_round_robin();
    logic [TAG_W-1:0] exp_tag;
    apply_reset();
    match_req_ready = 1'b1;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (req_ready !== (4'b0001 << (k % 4))) begin n_bad++; $display("FAIL rr_grant k=%0d got %b want %b", k, req_ready, 4'b0001 << (k % 4)); end
      @(negedge clk);
      exp_tag = TAG_W'(((k % 4) << 3) | ((k % 4) + 1));
      n_cmp++; if (match_req_valid !== 1'b1) begin n_bad++; $display("FAIL rr_valid k=%0d got %b want 1", k, match_req_valid); end
      n_cmp++; if (match_req_tag !== exp_tag) begin n_bad++; $display("FAIL rr_tag k=%0d got %h want %h", k, match_req_tag, exp_tag); end
      n_cmp++; if (match_req_head_addr !== 32'h1000_0000 + 32'((k % 4) * 16)) begin n_bad++; $display("FAIL rr_head k=%0d got %h", k, match_req_head_addr); end
    end
    #1;
    n_cmp++; if (outstanding !== 12'b001_001_001_010) begin n_bad++; $display("FAIL rr_outstanding got %b want 001001001010", outstanding); end
    req_valid = '0;
    @(negedge clk);
    n_cmp++; if (match_req_valid !== 1'b0) begin n_bad++; $display("FAIL rr_clear got %b want 0", match_req_valid); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    match_req_ready = 1'b0;
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_first_ready got %b want 0100", req_ready); end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (match_req_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid k=%0d got %b want 1", k, match_req_valid); end
      n_cmp++; if (match_req_head_addr !== 32'h1000_0020) begin n_bad++; $display("FAIL bp_head k=%0d got %h want 10000020", k, match_req_head_addr); end
      n_cmp++; if (match_req_history_addr !== 32'h2000_0002) begin n_bad++; $display("FAIL bp_hist k=%0d got %h want 20000002", k, match_req_history_addr); end
      n_cmp++; if (match_req_tag !== {2'd2, 3'd3}) begin n_bad++; $display("FAIL bp_tag k=%0d got %h want 13", k, match_req_tag); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready_low k=%0d got %b want 0000", k, req_ready); end
      @(negedge clk);
    end
    match_req_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_resume_ready got %b want 0100", req_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (out_of(2) !== 3'd2) begin n_bad++; $display("FAIL bp_cnt_a got %0d want 2", out_of(2)); end
    @(negedge clk);
    #1;
    n_cmp++; if (out_of(2) !== 3'd3) begin n_bad++; $display("FAIL bp_cnt_b got %0d want 3", out_of(2)); end
    req_valid = '0;
    @(negedge clk);
    n_cmp++; if (match_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got %b want 0", match_req_valid); end
  endtask

  task automatic test_credit_limit();
    apply_reset();
    match_req_ready = 1'b1;
    req_valid = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL cr_grant k=%0d got %b want 0010", k, req_ready); end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (out_of(1) !== 3'd4) begin n_bad++; $display("FAIL cr_full got %0d want 4", out_of(1)); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL cr_blocked got %b want 0000", req_ready); end
    req_valid = 4'b1010;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL cr_skip got %b want 1000", req_ready); end
    @(negedge clk);
    n_cmp++; if (match_req_tag[4:3] !== 2'd3) begin n_bad++; $display("FAIL cr_tag3 got %0d want 3", match_req_tag[4:3]); end
    req_valid = 4'b0010;
    match_resp_valid = 1'b1;
    match_resp_tag = {2'd1, 3'd2};
    match_resp_match_len = 6'd3;
    resp_ready = 4'b0010;
    #1;
    n_cmp++; if (resp_valid !== 4'b0010) begin n_bad++; $display("FAIL cr_resp_valid got %b want 0010", resp_valid); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL cr_still_full got %b want 0000", req_ready); end
    @(negedge clk);
    match_resp_valid = 1'b0;
    resp_ready = '0;
    #1;
    n_cmp++; if (out_of(1) !== 3'd3) begin n_bad++; $display("FAIL cr_after_resp got %0d want 3", out_of(1)); end
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL cr_regrant got %b want 0010", req_ready); end
  endtask

  task automatic test_resp_demux();
    apply_reset();
    match_req_ready = 1'b1;
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    match_resp_valid = 1'b1;
    match_resp_tag = {2'd2, 3'd5};
    match_resp_match_len = 6'd17;
    resp_ready = 4'b1011;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++; if (resp_valid !== 4'b0100) begin n_bad++; $display("FAIL dm_valid k=%0d got %b want 0100", k, resp_valid); end
      n_cmp++; if (match_resp_ready !== 1'b0) begin n_bad++; $display("FAIL dm_stall k=%0d got %b want 0", k, match_resp_ready); end
      n_cmp++; if (resp_local_tag !== 3'd5) begin n_bad++; $display("FAIL dm_ltag k=%0d got %0d want 5", k, resp_local_tag); end
      n_cmp++; if (resp_match_len !== 6'd17) begin n_bad++; $display("FAIL dm_len k=%0d got %0d want 17", k, resp_match_len); end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (out_of(2) !== 3'd1) begin n_bad++; $display("FAIL dm_cnt_held got %0d want 1", out_of(2)); end
    resp_ready = 4'b0100;
    #1;
    n_cmp++; if (match_resp_ready !== 1'b1) begin n_bad++; $display("FAIL dm_ready got %b want 1", match_resp_ready); end
    @(negedge clk);
    match_resp_valid = 1'b0;
    resp_ready = '0;
    #1;
    n_cmp++; if (out_of(2) !== 3'd0) begin n_bad++; $display("FAIL dm_cnt_dec got %0d want 0", out_of(2)); end
    n_cmp++; if (err_unexpected_resp !== 1'b0) begin n_bad++; $display("FAIL dm_err got %b want 0", err_unexpected_resp); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    match_req_ready = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    match_resp_valid = 1'b1;
    match_resp_tag = {2'd0, 3'd1};
    resp_ready = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL sim_grant got %b want 0001", req_ready); end
    n_cmp++; if (match_resp_ready !== 1'b1) begin n_bad++; $display("FAIL sim_resp_ready got %b want 1", match_resp_ready); end
    @(negedge clk);
    req_valid = '0;
    match_resp_valid = 1'b0;
    resp_ready = '0;
    #1;
    n_cmp++; if (out_of(0) !== 3'd1) begin n_bad++; $display("FAIL sim_cnt got %0d want 1", out_of(0)); end
    n_cmp++; if (err_unexpected_resp !== 1'b0) begin n_bad++; $display("FAIL sim_err got %b want 0", err_unexpected_resp); end
  endtask

  task automatic test_error_flag();
    apply_reset();
    match_resp_valid = 1'b1;
    match_resp_tag = {2'd3, 3'd0};
    resp_ready = 4'b1000;
    #1;
    n_cmp++; if (resp_valid !== 4'b1000) begin n_bad++; $display("FAIL err_resp_valid got %b want 1000", resp_valid); end
    n_cmp++; if (err_unexpected_resp !== 1'b0) begin n_bad++; $display("FAIL err_pre got %b want 0", err_unexpected_resp); end
    @(negedge clk);
    match_resp_valid = 1'b0;
    resp_ready = '0;
    #1;
    n_cmp++; if (err_unexpected_resp !== 1'b1) begin n_bad++; $display("FAIL err_set got %b want 1", err_unexpected_resp); end
    n_cmp++; if (out_of(3) !== 3'd0) begin n_bad++; $display("FAIL err_cnt got %0d want 0", out_of(3)); end
    repeat (3) @(negedge clk);
    n_cmp++; if (err_unexpected_resp !== 1'b1) begin n_bad++; $display("FAIL err_sticky got %b want 1", err_unexpected_resp); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (err_unexpected_resp !== 1'b0) begin n_bad++; $display("FAIL err_cleared got %b want 0", err_unexpected_resp); end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_head_addr[i*ADDR_W +: ADDR_W]           = 32'h1000_0000 + 32'(i * 16);
      req_history_addr[i*ADDR_W +: ADDR_W]        = 32'h2000_0000 + 32'(i);
      req_local_tag[i*LOCAL_TAG_W +: LOCAL_TAG_W] = LOCAL_TAG_W'(i + 1);
    end
    test_reset();
    test_round_robin();
    test_backpressure();
    test_credit_limit();
    test_resp_demux();
    test_simultaneous();
    test_error_flag();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
